// File: rtl/mem_access_unit.sv
// mem_access_unit: sized/aligned RAM access sequencer with two-beat doublewords, lane enables and wait timeout
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 15,
  parameter int TMR_W = 4,
  parameter bit BIG_ENDIAN = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata,
  output logic              done,
  output logic              busy,
  output logic              trap_misalign,
  output logic              bus_err,
  output logic              mem_mov,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_moc
);
  typedef enum logic [2:0] {IDLE, BEAT1, BEAT2, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic rw_q, sign_q, mis_q;
  logic [1:0] size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0] wdata_q, rdata_q;
  logic [31:0] hi_q;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic accept, misaligned, in_beat, beat_ok;
  logic [4:0] sh;
  logic [15:0] lane;
  logic [31:0] ld_ext, wd;
  logic [3:0] be_big, be_lane;
  assign accept = state_q == IDLE && req;
  assign misaligned = (size == 2'b01 && addr[0]) || (size == 2'b10 && |addr[1:0]) ||
                      (size == 2'b11 && |addr[2:0]);
  assign in_beat = state_q == BEAT1 || state_q == BEAT2;
  assign beat_ok = in_beat && mem_moc;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = misaligned ? ERR : BEAT1;
        cnt_d = '0;
      end
      BEAT1, BEAT2: if (mem_moc) begin
        state_d = (state_q == BEAT1 && size_q == 2'b11) ? BEAT2 : DONE;
        cnt_d = '0;
      end else if (cnt_q == TMR_W'(TIMEOUT - 1)) begin
        state_d = ERR;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // shift distance that brings the addressed lane(s) down to bit 0
  assign sh = size_q == 2'b00 ? (BIG_ENDIAN ? {~addr_q[1:0], 3'b000} : {addr_q[1:0], 3'b000}) :
              size_q == 2'b01 ? (BIG_ENDIAN ? {~addr_q[1], 4'b0000} : {addr_q[1], 4'b0000}) : 5'd0;
  assign lane = 16'(mem_rdata >> sh);
  assign ld_ext = size_q == 2'b00 ? {{24{sign_q & lane[7]}}, lane[7:0]} :
                  size_q == 2'b01 ? {{16{sign_q & lane[15]}}, lane} : mem_rdata;
  assign be_big = size_q == 2'b00 ? 4'b1000 >> addr_q[1:0] :
                  size_q == 2'b01 ? (addr_q[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign be_lane = BIG_ENDIAN ? be_big : {be_big[0], be_big[1], be_big[2], be_big[3]};
  assign wd = size_q == 2'b00 ? {4{wdata_q[7:0]}} :
              size_q == 2'b01 ? {2{wdata_q[15:0]}} :
              (size_q == 2'b11 && state_q == BEAT1) ? wdata_q[63:32] : wdata_q[31:0];
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rw_q <= 1'b0;
      sign_q <= 1'b0;
      mis_q <= 1'b0;
      size_q <= 2'b00;
      addr_q <= '0;
      wdata_q <= '0;
      hi_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (accept) begin
        rw_q <= rw;
        sign_q <= sign;
        size_q <= size;
        addr_q <= addr;
        wdata_q <= wdata;
        mis_q <= misaligned;
      end
      // the first doubleword beat is parked so rdata only changes once the access completes
      if (beat_ok && rw_q) begin
        if (size_q == 2'b11 && state_q == BEAT1) hi_q <= mem_rdata;
        else rdata_q <= size_q == 2'b11 ? {hi_q, mem_rdata} : {32'b0, ld_ext};
      end
    end
  end
  assign rdata = rdata_q;
  assign done = state_q == DONE;
  assign busy = state_q != IDLE;
  assign trap_misalign = state_q == ERR && mis_q;
  assign bus_err = state_q == ERR && !mis_q;
  assign mem_mov = in_beat;
  assign mem_rw = rw_q;
  assign mem_addr = in_beat ? {addr_q[ADDR_W-1:2], 2'b00} + (state_q == BEAT2 ? ADDR_W'(4) : '0) : '0;
  assign mem_be = in_beat ? be_lane : 4'b0000;
  assign mem_wdata = in_beat ? wd : 32'b0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table vectors, corner sequences and randomized accesses against a byte-level model
module tb_mem_access_unit;
  localparam int AW = 32;
  localparam int TO = 15;
  localparam bit BE = 1;
  logic clk = 0, clr, req, rw, sign, mem_moc;
  logic [1:0] size;
  logic [AW-1:0] addr, mem_addr;
  logic [63:0] wdata, rdata;
  logic done, busy, trap_misalign, bus_err, mem_mov, mem_rw;
  logic [3:0] mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  int errors = 0, checks = 0;
  logic [63:0] last_rd = '0;
  always #5 clk = ~clk;
  mem_access_unit #(.ADDR_W(AW), .TIMEOUT(TO), .TMR_W(4), .BIG_ENDIAN(BE)) dut (
    .clk(clk), .clr(clr), .req(req), .rw(rw), .size(size), .sign(sign), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .busy(busy), .trap_misalign(trap_misalign),
    .bus_err(bus_err), .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_moc(mem_moc));
  typedef struct {
    logic rw;
    logic [1:0] size;
    logic sign;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [31:0] w1, w2;
    int waits;
    logic [3:0] be;
    logic [63:0] rd;
  } vec_t;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] byte_at(input logic [31:0] w, input int k);
    return BE ? w[31-8*k -: 8] : w[8*k +: 8];
  endfunction
  function automatic logic [63:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                                           input logic [31:0] w1, input logic [31:0] w2);
    int off = int'(a[1:0]);
    logic [7:0] b0, b1;
    logic [31:0] r;
    b0 = byte_at(w1, off);
    b1 = byte_at(w1, (off + 1) % 4);
    if (sz == 2'd3) return {w1, w2};
    if (sz == 2'd2) return {32'b0, w1};
    if (sz == 2'd0) begin
      r = {24'b0, b0};
      if (sg && b0[7]) r = r | 32'hFFFFFF00;
    end else begin
      r = BE ? {16'b0, b0, b1} : {16'b0, b1, b0};
      if (sg && r[15]) r = r | 32'hFFFF0000;
    end
    return {32'b0, r};
  endfunction
  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] m = '0;
    int n = sz >= 2 ? 4 : (1 << sz);
    int off = sz >= 2 ? 0 : int'(a[1:0]);
    for (int k = off; k < off + n; k++) m[BE ? 3 - k : k] = 1'b1;
    return m;
  endfunction
  function automatic logic [31:0] ref_wd(input logic [1:0] sz, input logic [63:0] d, input int beat);
    if (sz == 2'd0) return {4{d[7:0]}};
    if (sz == 2'd1) return {2{d[15:0]}};
    if (sz == 2'd3 && beat == 1) return d[63:32];
    return d[31:0];
  endfunction
  task automatic run(input vec_t v, input string n);
    int nb = v.size == 2'd3 ? 2 : 1;
    logic [63:0] exp;
    req = 1; rw = v.rw; size = v.size; sign = v.sign; addr = v.addr; wdata = v.wdata;
    tick;
    req = 0;
    for (int b = 1; b <= nb; b++) begin
      for (int i = 0; i <= v.waits; i++) begin
        mem_moc = (i == v.waits);
        mem_rdata = b == 1 ? v.w1 : v.w2;
        chk({n, " mov"}, 64'(mem_mov), 64'd1);
        if (i == 0) begin
          chk({n, " addr"}, 64'(mem_addr), 64'({v.addr[31:2], 2'b00} + 32'(4 * (b - 1))));
          chk({n, " be"}, 64'(mem_be), 64'(v.be));
          chk({n, " wdata"}, 64'(mem_wdata), 64'(ref_wd(v.size, v.wdata, b)));
          chk({n, " rw"}, 64'(mem_rw), 64'(v.rw));
        end
        tick;
      end
      mem_moc = 0;
    end
    exp = v.rw ? v.rd : last_rd;
    chk({n, " done"}, 64'(done), 64'd1);
    chk({n, " mov off"}, 64'(mem_mov), 64'd0);
    chk({n, " rdata"}, rdata, exp);
    tick;
    chk({n, " done end"}, 64'(done), 64'd0);
    chk({n, " idle"}, 64'(busy), 64'd0);
    last_rd = exp;
  endtask
  initial begin
    vec_t tbl[5];
    vec_t v;
    int n;
    tbl[0] = '{1'b1, 2'd0, 1'b0, 32'h103, 64'h0, 32'h11223344, 32'h0, 2, 4'b0001, 64'h44};
    tbl[1] = '{1'b1, 2'd1, 1'b1, 32'h102, 64'h0, 32'h12348001, 32'h0, 0, 4'b0011, 64'hFFFF8001};
    tbl[2] = '{1'b1, 2'd3, 1'b0, 32'h200, 64'h0, 32'hAAAA0001, 32'hBBBB0002, 1, 4'b1111, 64'hAAAA0001BBBB0002};
    tbl[3] = '{1'b0, 2'd2, 1'b0, 32'h40, 64'hDEADBEEF, 32'h0, 32'h0, 0, 4'b1111, 64'h0};
    tbl[4] = '{1'b0, 2'd0, 1'b0, 32'h2, 64'h5A, 32'h0, 32'h0, 0, 4'b0010, 64'h0};
    clr = 1; req = 0; rw = 0; size = 0; sign = 0; addr = '0; wdata = '0; mem_moc = 0; mem_rdata = '0;
    tick; tick;
    clr = 0;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst mov", 64'(mem_mov), 64'd0);
    chk("rst be", 64'(mem_be), 64'd0);
    chk("rst errs", 64'({trap_misalign, bus_err}), 64'd0);
    chk("rst rdata", rdata, 64'd0);
    for (int i = 0; i < 3; i++) run(tbl[i], $sformatf("vec%0d", i));
    req = 1; rw = 0; size = 2'd1; addr = 32'h101; wdata = 64'h1234;
    tick;
    req = 0;
    chk("mis trap", 64'(trap_misalign), 64'd1);
    chk("mis busy", 64'(busy), 64'd1);
    chk("mis mov", 64'(mem_mov), 64'd0);
    chk("mis done", 64'(done), 64'd0);
    tick;
    chk("mis trap end", 64'(trap_misalign), 64'd0);
    chk("mis busy end", 64'(busy), 64'd0);
    chk("mis rdata", rdata, last_rd);
    req = 1; rw = 1; size = 2'd2; addr = 32'h10;
    tick;
    req = 0; mem_moc = 0; n = 0;
    for (int i = 0; i < 40 && !bus_err; i++) begin
      if (mem_mov) n++;
      tick;
    end
    chk("to bus_err", 64'(bus_err), 64'd1);
    chk("to mov", 64'(mem_mov), 64'd0);
    chk("to wait cycles", 64'(n), 64'(TO));
    chk("to done", 64'(done), 64'd0);
    tick;
    chk("to bus_err end", 64'(bus_err), 64'd0);
    chk("to busy end", 64'(busy), 64'd0);
    run(tbl[3], "vec3");
    req = 1; rw = 1; size = 2'd3; addr = 32'h300;
    tick;
    req = 0; mem_moc = 1; mem_rdata = 32'h01020304;
    tick;
    mem_moc = 0;
    chk("rst2 mov", 64'(mem_mov), 64'd1);
    chk("rst2 addr", 64'(mem_addr), 64'h304);
    clr = 1;
    tick;
    clr = 0;
    chk("rst2 mov off", 64'(mem_mov), 64'd0);
    chk("rst2 busy", 64'(busy), 64'd0);
    chk("rst2 flags", 64'({done, bus_err, trap_misalign}), 64'd0);
    chk("rst2 rdata", rdata, 64'd0);
    last_rd = '0;
    tick;
    chk("rst2 flags later", 64'({done, bus_err, trap_misalign}), 64'd0);
    run(tbl[4], "vec4");
    for (int i = 0; i < 40; i++) begin
      v.rw = 1'($urandom);
      v.size = 2'($urandom);
      v.sign = 1'($urandom);
      v.addr = $urandom & ~((32'd1 << v.size) - 32'd1);
      v.wdata = {$urandom, $urandom};
      v.w1 = $urandom;
      v.w2 = $urandom;
      v.waits = $urandom_range(0, 4);
      v.be = ref_be(v.size, v.addr);
      v.rd = ref_load(v.size, v.sign, v.addr, v.w1, v.w2);
      run(v, $sformatf("rnd%0d", i));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
